// File: rtl/pancham_if.sv
// pancham_if: request/digest bundle between a candidate driver and pancham_core.
// The master drives the message; the slave returns ready and the digest strobe.
interface pancham_if;
    logic [127:0] msg_in;
    logic [7:0]   msg_in_width;
    logic         msg_in_valid;
    logic         ready;
    logic [127:0] msg_output;
    logic         msg_out_valid;

    modport master (
        output msg_in, msg_in_width, msg_in_valid,
        input  ready, msg_output, msg_out_valid
    );

    modport slave (
        input  msg_in, msg_in_width, msg_in_valid,
        output ready, msg_output, msg_out_valid
    );
endinterface

// File: rtl/pancham_core.sv
// pancham_core: iterative single-block MD5 engine for messages of 0..128 bits.
// Define PANCHAM_TWO_STEP_EN to chain two MD5 steps per ROUND cycle.
module pancham_core (
    input  logic     clk,
    input  logic     reset,
    pancham_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, ROUND, DONE} state_t;

    localparam logic [31:0] IV_A = 32'h67452301;
    localparam logic [31:0] IV_B = 32'hefcdab89;
    localparam logic [31:0] IV_C = 32'h98badcfe;
    localparam logic [31:0] IV_D = 32'h10325476;

`ifdef PANCHAM_TWO_STEP_EN
    localparam logic [5:0] STEP_INC  = 6'd2;
    localparam logic [5:0] LAST_STEP = 6'd62;
`else
    localparam logic [5:0] STEP_INC  = 6'd1;
    localparam logic [5:0] LAST_STEP = 6'd63;
`endif

    localparam logic [31:0] T_TAB [64] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
        32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
        32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
        32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
        32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
        32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
        32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
        32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
        32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
    };

    localparam logic [4:0] S_TAB [16] = '{
        5'd7, 5'd12, 5'd17, 5'd22,
        5'd5, 5'd9,  5'd14, 5'd20,
        5'd4, 5'd11, 5'd16, 5'd23,
        5'd6, 5'd10, 5'd15, 5'd21
    };

    function automatic logic [31:0] bswap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    // State packs {A,B,C,D}; returns the state after step i.
    function automatic logic [127:0] md5_step(
        input logic [127:0] st,
        input logic [5:0]   i,
        input logic [511:0] m
    );
        logic [31:0] a, b, c, d, f, sum, rot;
        logic [3:0]  g;
        logic [4:0]  s;
        {a, b, c, d} = st;
        unique case (i[5:4])
            2'd0: begin f = (b & c) | (~b & d); g = i[3:0]; end
            2'd1: begin f = (b & d) | (c & ~d); g = i[3:0] * 4'd5 + 4'd1; end
            2'd2: begin f = b ^ c ^ d;          g = i[3:0] * 4'd3 + 4'd5; end
            default: begin f = c ^ (b | ~d);    g = i[3:0] * 4'd7; end
        endcase
        s   = S_TAB[{i[5:4], i[1:0]}];
        sum = a + f + m[{g, 5'b0} +: 32] + T_TAB[i];
        rot = (sum << s) | (sum >> (6'd32 - {1'b0, s}));
        return {d, b + rot, b, c};
    endfunction

    state_t         state, state_n;
    logic           ready_q, ready_n;
    logic           valid_q, valid_n;
    logic           accept;
    logic [127:0]   msg_q;
    logic [7:0]     width_q, w_eff;
    logic [511:0]   blk, blk_n;
    logic [31:0]    a, b, c, d;
    logic [5:0]     step;
    logic [127:0]   digest_q;
    logic [127:0]   st_one, st_next;

    assign accept = (state == IDLE) && ready_q && bus.msg_in_valid;
    assign w_eff  = (bus.msg_in_width > 8'd128) ? 8'd128
                  : {bus.msg_in_width[7:3], 3'b000};

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (accept) state_n = LOAD;
            LOAD:    state_n = ROUND;
            ROUND:   if (step == LAST_STEP) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        ready_n = (state_n == IDLE);
        valid_n = (state == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    // Padding byte lands right after the last message byte, even at W=128.
    always_comb begin
        blk_n = '0;
        for (int k = 0; k < 16; k++)
            if (5'(k) < width_q[7:3])
                blk_n[8*k +: 8] = msg_q[8*k +: 8];
        blk_n[{width_q[7:3], 3'b000} +: 8] = 8'h80;
        blk_n[448 +: 32] = {24'h0, width_q};
    end

    always_comb begin
        st_one = md5_step({a, b, c, d}, step, blk);
`ifdef PANCHAM_TWO_STEP_EN
        st_next = md5_step(st_one, step | 6'd1, blk);
`else
        st_next = st_one;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_q  <= 1'b0;
            valid_q  <= 1'b0;
            msg_q    <= '0;
            width_q  <= '0;
            blk      <= '0;
            {a, b, c, d} <= '0;
            step     <= '0;
            digest_q <= '0;
        end else begin
            ready_q <= ready_n;
            valid_q <= valid_n;
            if (accept) begin
                msg_q   <= bus.msg_in;
                width_q <= w_eff;
            end
            unique case (state)
                LOAD: begin
                    blk          <= blk_n;
                    {a, b, c, d} <= {IV_A, IV_B, IV_C, IV_D};
                    step         <= '0;
                end
                ROUND: begin
                    {a, b, c, d} <= st_next;
                    step         <= step + STEP_INC;
                end
                DONE: digest_q <= {bswap(a + IV_A), bswap(b + IV_B),
                                   bswap(c + IV_C), bswap(d + IV_D)};
                default: ;
            endcase
        end
    end

    assign bus.ready         = ready_q;
    assign bus.msg_out_valid = valid_q;
    assign bus.msg_output    = digest_q;
endmodule

// File: tb/tb_pancham_core.sv
// tb_pancham_core: randomized self-checking bench for the MD5 engine,
// using known digests plus a byte-oriented MD5 model built from sin().
module tb_pancham_core;
`ifdef PANCHAM_TWO_STEP_EN
    localparam int LAT = 34;
`else
    localparam int LAT = 66;
`endif

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    pancham_if bus();

    pancham_core dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int s);
        return (x << s) | (x >> (32 - s));
    endfunction

    function automatic logic [127:0] md5_ref(input logic [127:0] msg,
                                             input logic [7:0] width);
        logic [7:0]   by [64];
        logic [31:0]  mw [16];
        logic [31:0]  k, f, tmp, ra, rb, rc, rd;
        logic [127:0] res;
        int           nb, g, s;
        real          r;
        int           sh [4][4] = '{'{7, 12, 17, 22}, '{5, 9, 14, 20},
                                    '{4, 11, 16, 23}, '{6, 10, 15, 21}};
        nb = (width > 8'd128) ? 16 : int'(width) / 8;
        for (int j = 0; j < 64; j++) by[j] = 8'h00;
        for (int j = 0; j < nb; j++) by[j] = msg[8*j +: 8];
        by[nb] = 8'h80;
        by[56] = 8'(nb * 8);
        for (int j = 0; j < 16; j++)
            mw[j] = {by[4*j+3], by[4*j+2], by[4*j+1], by[4*j]};
        ra = 32'h67452301; rb = 32'hefcdab89;
        rc = 32'h98badcfe; rd = 32'h10325476;
        for (int i = 0; i < 64; i++) begin
            r = $sin(real'(i + 1));
            if (r < 0.0) r = -r;
            k = 32'(longint'($floor(r * 4294967296.0)));
            if (i < 16)      begin f = (rb & rc) | (~rb & rd); g = i; end
            else if (i < 32) begin f = (rb & rd) | (rc & ~rd); g = (5*i + 1) % 16; end
            else if (i < 48) begin f = rb ^ rc ^ rd;           g = (3*i + 5) % 16; end
            else             begin f = rc ^ (rb | ~rd);        g = (7*i) % 16; end
            s   = sh[i / 16][i % 4];
            tmp = rd; rd = rc; rc = rb;
            rb  = rb + rotl(ra + f + k + mw[g], s);
            ra  = tmp;
        end
        ra += 32'h67452301; rb += 32'hefcdab89;
        rc += 32'h98badcfe; rd += 32'h10325476;
        for (int j = 0; j < 4; j++) begin
            res[127 - 8*j -: 8]      = ra[8*j +: 8];
            res[127 - 8*(j+4) -: 8]  = rb[8*j +: 8];
            res[127 - 8*(j+8) -: 8]  = rc[8*j +: 8];
            res[127 - 8*(j+12) -: 8] = rd[8*j +: 8];
        end
        return res;
    endfunction

    // Runs one job; lat=0 means no strobe within the bound.
    task automatic do_job(input logic [127:0] m, input logic [7:0] w,
                          output logic [127:0] dig, output int lat,
                          output bit rdy_at_done, output bit low_after);
        int n;
        bus.msg_in = m;
        bus.msg_in_width = w;
        bus.msg_in_valid = 1'b1;
        n = 0;
        while (bus.ready !== 1'b1 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        bus.msg_in_valid = 1'b0;
        lat = 0;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            if (bus.msg_out_valid === 1'b1) begin lat = c; break; end
        end
        dig = bus.msg_output;
        rdy_at_done = (bus.ready === 1'b1);
        @(posedge clk); #1;
        low_after = (bus.msg_out_valid === 1'b0);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        bus.msg_in = {4{$urandom}};
        bus.msg_in_width = 8'd0;
        bus.msg_in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.ready !== 1'b0) begin
            failures++; $display("FAIL reset_ready got=%b exp=0", bus.ready);
        end
        checks++;
        if (bus.msg_out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_valid got=%b exp=0", bus.msg_out_valid);
        end
        checks++;
        if (bus.msg_output !== 128'h0) begin
            failures++; $display("FAIL reset_output got=%h exp=0", bus.msg_output);
        end
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        bus.msg_in_valid = 1'b0;
        checks++;
        if (bus.ready !== 1'b1) begin
            failures++; $display("FAIL reset_release_ready got=%b exp=1", bus.ready);
        end
    endtask

    task automatic test_known;
        string        s;
        logic [127:0] m [4];
        logic [7:0]   w [4];
        logic [127:0] e [4];
        logic [127:0] dig;
        int           lat;
        bit           rdy, low;
        s = "message digest";
        m[0] = '0; w[0] = 8'd0;   e[0] = 128'hd41d8cd98f00b204e9800998ecf8427e;
        m[1] = 128'h61; w[1] = 8'd8; e[1] = 128'h0cc175b9c0f1b6a831c399e269772661;
        m[2] = 128'h636261; w[2] = 8'd24; e[2] = 128'h900150983cd24fb0d6963f7d28e17f72;
        m[3] = '0; w[3] = 8'd112; e[3] = 128'hf96b697d7cb7938d525a2f31aaf161d0;
        for (int j = 0; j < 14; j++) m[3][8*j +: 8] = s[j];
        for (int t = 0; t < 4; t++) begin
            do_job(m[t], w[t], dig, lat, rdy, low);
            checks++;
            if (dig !== e[t]) begin
                failures++; $display("FAIL known_digest[%0d] got=%h exp=%h", t, dig, e[t]);
            end
            checks++;
            if (lat != LAT) begin
                failures++; $display("FAIL known_latency[%0d] got=%0d exp=%0d", t, lat, LAT);
            end
            checks++;
            if (!rdy || !low) begin
                failures++;
                $display("FAIL known_strobe[%0d] ready_at_done=%b one_cycle=%b exp=1/1", t, rdy, low);
            end
        end
    endtask

    task automatic test_random;
        logic [127:0] m, dig, exp_d;
        logic [7:0]   w;
        int           lat;
        bit           rdy, low;
        for (int t = 0; t < 10; t++) begin
            m = {$urandom, $urandom, $urandom, $urandom};
            w = (t == 0) ? 8'd200 : (t == 1) ? 8'd13 : 8'($urandom_range(0, 255));
            exp_d = md5_ref(m, w);
            do_job(m, w, dig, lat, rdy, low);
            checks++;
            if (dig !== exp_d || lat != LAT) begin
                failures++;
                $display("FAIL random[%0d] w=%0d got=%h lat=%0d exp=%h lat=%0d",
                         t, w, dig, lat, exp_d, LAT);
            end
        end
    endtask

    task automatic test_w128_stable;
        logic [127:0] m, d1, d2, d3;
        int           lat;
        bit           rdy, low;
        m = {$urandom, $urandom, $urandom, $urandom};
        do_job(m, 8'd128, d1, lat, rdy, low);
        do_job(m, 8'd128, d2, lat, rdy, low);
        do_job(m, 8'd112, d3, lat, rdy, low);
        checks++;
        if (d1 !== md5_ref(m, 8'd128)) begin
            failures++; $display("FAIL w128_first got=%h exp=%h", d1, md5_ref(m, 8'd128));
        end
        checks++;
        if (d2 !== md5_ref(m, 8'd128)) begin
            failures++; $display("FAIL w128_repeat got=%h exp=%h", d2, md5_ref(m, 8'd128));
        end
        checks++;
        if (d3 !== md5_ref(m, 8'd112) || d3 === d1) begin
            failures++; $display("FAIL w112_differs got=%h exp=%h", d3, md5_ref(m, 8'd112));
        end
    endtask

    task automatic test_busy_ignore;
        logic [127:0] m, exp_d;
        logic [7:0]   w;
        int           lat, rdy_hi;
        m = {$urandom, $urandom, $urandom, $urandom};
        w = 8'd72;
        exp_d = md5_ref(m, w);
        bus.msg_in = m;
        bus.msg_in_width = w;
        bus.msg_in_valid = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        rdy_hi = 0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            bus.msg_in = {$urandom, $urandom, $urandom, $urandom};
            bus.msg_in_width = 8'($urandom);
            bus.msg_in_valid = 1'($urandom);
            @(posedge clk); #1;
            if (bus.msg_out_valid === 1'b1) begin
                lat = c; bus.msg_in_valid = 1'b0; break;
            end
            if (bus.ready === 1'b1) rdy_hi++;
        end
        checks++;
        if (bus.msg_output !== exp_d || lat != LAT) begin
            failures++;
            $display("FAIL busy_ignore got=%h lat=%0d exp=%h lat=%0d",
                     bus.msg_output, lat, exp_d, LAT);
        end
        checks++;
        if (rdy_hi != 0) begin
            failures++; $display("FAIL busy_ready got=%0d high cycles exp=0", rdy_hi);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        logic [127:0] m [4];
        logic [7:0]   w [4];
        int           lat, exp_lat;
        for (int j = 0; j < 4; j++) begin
            m[j] = {$urandom, $urandom, $urandom, $urandom};
            w[j] = 8'($urandom_range(0, 16) * 8);
        end
        bus.msg_in = m[0];
        bus.msg_in_width = w[0];
        bus.msg_in_valid = 1'b1;
        @(posedge clk); #1;
        for (int j = 0; j < 3; j++) begin
            lat = 0;
            exp_lat = (j == 0) ? LAT : LAT + 1;
            for (int c = 1; c <= 200; c++) begin
                @(posedge clk); #1;
                if (c == 1 && j > 0) begin
                    checks++;
                    if (bus.ready !== 1'b0) begin
                        failures++; $display("FAIL b2b_accept[%0d] ready=%b exp=0", j, bus.ready);
                    end
                end
                if (bus.msg_out_valid === 1'b1) begin lat = c; break; end
            end
            checks++;
            if (bus.msg_output !== md5_ref(m[j], w[j]) || lat != exp_lat) begin
                failures++;
                $display("FAIL b2b[%0d] got=%h gap=%0d exp=%h gap=%0d", j,
                         bus.msg_output, lat, md5_ref(m[j], w[j]), exp_lat);
            end
            bus.msg_in = m[j+1];
            bus.msg_in_width = w[j+1];
            if (j == 2) bus.msg_in_valid = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_abort;
        logic [127:0] dig;
        int           lat, pulses;
        bit           rdy, low;
        bus.msg_in = {$urandom, $urandom, $urandom, $urandom};
        bus.msg_in_width = 8'd128;
        bus.msg_in_valid = 1'b1;
        while (bus.ready !== 1'b1) begin @(posedge clk); #1; end
        @(posedge clk); #1;
        bus.msg_in_valid = 1'b0;
        repeat (32) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        checks++;
        if (bus.msg_output !== 128'h0 || bus.ready !== 1'b0 || bus.msg_out_valid !== 1'b0) begin
            failures++;
            $display("FAIL abort_async out=%h ready=%b valid=%b exp=0/0/0",
                     bus.msg_output, bus.ready, bus.msg_out_valid);
        end
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        pulses = 0;
        for (int c = 0; c < LAT + 10; c++) begin
            @(posedge clk); #1;
            if (bus.msg_out_valid === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            failures++; $display("FAIL abort_no_valid got=%0d pulses exp=0", pulses);
        end
        do_job(128'h636261, 8'd24, dig, lat, rdy, low);
        checks++;
        if (dig !== 128'h900150983cd24fb0d6963f7d28e17f72 || lat != LAT) begin
            failures++;
            $display("FAIL abort_next_job got=%h lat=%0d exp=900150983cd24fb0d6963f7d28e17f72 lat=%0d",
                     dig, lat, LAT);
        end
    endtask

    initial begin
        test_reset();
        test_known();
        test_random();
        test_w128_stable();
        test_busy_ignore();
        test_back_to_back();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog elapsed=%0t limit=2000000", $time);
        $fatal(1, "watchdog");
    end
endmodule
